// File: rtl/frame_sequencer_pkg.sv
// frame_sequencer_pkg: shared widths, instruction layout, FSM encodings and instruction builder.
package frame_sequencer_pkg;
    localparam int INSTRUCTION_WIDTH = 32;
    localparam int X_COORD_WIDTH = 8;
    localparam int Y_COORD_WIDTH = 7;
    localparam int COLOUR_WIDTH = 3;
    localparam int X_LSB = 4;
    localparam int Y_LSB = 12;
    localparam int COL_LSB = 19;
    localparam int WE_BIT = 22;
    localparam logic [3:0] OPCODE_DRAW = 4'h1;
    localparam logic [3:0] OPCODE_DISPLAY = 4'h2;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_ACK  = 3'd2,
        WAIT_DONE = 3'd3,
        ADVANCE   = 3'd4,
        DONE      = 3'd5
    } state_t;

    typedef enum logic {
        MODE_REFRESH = 1'b0,
        MODE_CLEAR   = 1'b1
    } mode_t;

    function automatic logic [INSTRUCTION_WIDTH-1:0] make_instr(
        input mode_t m,
        input logic [X_COORD_WIDTH-1:0] x,
        input logic [Y_COORD_WIDTH-1:0] y,
        input logic [COLOUR_WIDTH-1:0] c
    );
        logic [INSTRUCTION_WIDTH-1:0] i;
        i = '0;
        i[3:0] = (m == MODE_CLEAR) ? OPCODE_DRAW : OPCODE_DISPLAY;
        i[X_LSB +: X_COORD_WIDTH] = x;
        i[Y_LSB +: Y_COORD_WIDTH] = y;
        if (m == MODE_CLEAR) begin
            i[COL_LSB +: COLOUR_WIDTH] = c;
            i[WE_BIT] = 1'b1;
        end
        return i;
    endfunction
endpackage

// File: rtl/frame_sequencer_raster_counter.sv
// raster_counter: raster-order x/y pixel counter with synchronous clear and advance.
module raster_counter
    import frame_sequencer_pkg::*;
#(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic advance,
    output logic [X_COORD_WIDTH-1:0] x,
    output logic [Y_COORD_WIDTH-1:0] y,
    output logic last_pixel
);
    localparam logic [X_COORD_WIDTH-1:0] X_MAX = X_COORD_WIDTH'(SCREEN_W - 1);
    localparam logic [Y_COORD_WIDTH-1:0] Y_MAX = Y_COORD_WIDTH'(SCREEN_H - 1);

    logic last_x, last_y;

    assign last_x = (x == X_MAX);
    assign last_y = (y == Y_MAX);
    assign last_pixel = last_x && last_y;

    // y holds at the last row; the next pass clears the counter before use
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x <= '0;
            y <= '0;
        end else if (clr) begin
            x <= '0;
            y <= '0;
        end else if (advance) begin
            x <= last_x ? '0 : x + 1'b1;
            if (last_x && !last_y)
                y <= y + 1'b1;
        end
    end
endmodule

// File: rtl/frame_sequencer.sv
// frame_sequencer: walks the screen in raster order issuing DISPLAY or DRAW instructions per pixel.
module frame_sequencer
    import frame_sequencer_pkg::*;
#(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic clock,
    input  logic reset,
    input  logic refresh_req,
    input  logic clear_req,
    input  logic [COLOUR_WIDTH-1:0] clear_colour,
    input  logic dp_finished,
    output logic dp_start,
    output logic [INSTRUCTION_WIDTH-1:0] dp_instruction,
    output logic busy,
    output logic frame_done
);
    state_t state, state_n;
    mode_t mode;
    logic pend_clear, pend_refresh;
    logic [COLOUR_WIDTH-1:0] pend_colour, pass_colour;
    logic [X_COORD_WIDTH-1:0] x;
    logic [Y_COORD_WIDTH-1:0] y;
    logic last_pixel, take, issue;

    raster_counter #(.SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H)) u_raster (
        .clock(clock),
        .reset(reset),
        .clr(take),
        .advance(state == ADVANCE),
        .x(x),
        .y(y),
        .last_pixel(last_pixel)
    );

    always_comb begin
        state_n = state;
        take = (state == IDLE) && (pend_clear || pend_refresh);
        issue = (state == ISSUE) && dp_finished;
        case (state)
            IDLE:      state_n = take ? ISSUE : IDLE;
            ISSUE:     state_n = issue ? WAIT_ACK : ISSUE;
            WAIT_ACK:  state_n = dp_finished ? WAIT_ACK : WAIT_DONE;
            WAIT_DONE: state_n = dp_finished ? ADVANCE : WAIT_DONE;
            ADVANCE:   state_n = last_pixel ? DONE : ISSUE;
            DONE:      state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign frame_done = (state == DONE);

    // a new pulse on the consuming cycle is a fresh request and re-arms its flag
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            mode <= MODE_REFRESH;
            pend_clear <= 1'b0;
            pend_refresh <= 1'b0;
            pend_colour <= '0;
            pass_colour <= '0;
            dp_start <= 1'b0;
            dp_instruction <= '0;
        end else begin
            state <= state_n;
            pend_clear <= clear_req || (pend_clear && state != IDLE);
            pend_refresh <= refresh_req || (pend_refresh && !(state == IDLE && !pend_clear));
            if (clear_req)
                pend_colour <= clear_colour;
            if (take) begin
                mode <= pend_clear ? MODE_CLEAR : MODE_REFRESH;
                pass_colour <= pend_colour;
            end
            dp_start <= issue;
            if (issue)
                dp_instruction <= make_instr(mode, x, y, pass_colour);
        end
    end
endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer: directed checks of frame_sequencer on a 4x3 screen with a behavioural datapath.
module tb_frame_sequencer;
    import frame_sequencer_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic refresh_req = 1'b0;
    logic clear_req = 1'b0;
    logic [2:0] clear_colour = 3'b000;
    logic dp_finished;
    logic dp_start;
    logic [31:0] dp_instruction;
    logic busy;
    logic frame_done;

    int vecs = 0;
    int errs = 0;

    logic fin = 1'b1;
    logic hold_low = 1'b0;
    int cnt = 0;
    int lat = 3;

    logic [31:0] q[$];
    logic [31:0] cap;
    logic outstanding = 1'b0;
    logic in_pass = 1'b0;
    logic fin_prev = 1'b1;
    int frames = 0;
    int starts_at_done = 0;
    int stab_err = 0;
    int busy_gaps = 0;

    frame_sequencer #(.SCREEN_W(4), .SCREEN_H(3)) dut (
        .clock(clock),
        .reset(reset),
        .refresh_req(refresh_req),
        .clear_req(clear_req),
        .clear_colour(clear_colour),
        .dp_finished(dp_finished),
        .dp_start(dp_start),
        .dp_instruction(dp_instruction),
        .busy(busy),
        .frame_done(frame_done)
    );

    always #5 clock = ~clock;

    assign dp_finished = fin & ~hold_low;

    // datapath keeps running across sequencer reset
    always @(posedge clock) begin
        if (dp_start) begin
            fin <= 1'b0;
            cnt <= lat;
        end else if (cnt != 0) begin
            cnt <= cnt - 1;
            if (cnt == 1)
                fin <= 1'b1;
        end
    end

    always @(negedge clock) begin
        if (reset) begin
            outstanding = 1'b0;
            in_pass = 1'b0;
        end else begin
            if (dp_start) begin
                if (outstanding)
                    stab_err++;
                q.push_back(dp_instruction);
                cap = dp_instruction;
                outstanding = 1'b1;
                in_pass = 1'b1;
            end else if (outstanding) begin
                if (dp_instruction !== cap)
                    stab_err++;
                if (dp_finished && !fin_prev)
                    outstanding = 1'b0;
            end
            if (in_pass && !busy)
                busy_gaps++;
            if (frame_done) begin
                frames++;
                starts_at_done = q.size();
                in_pass = 1'b0;
            end
        end
        fin_prev = dp_finished;
    end

    function automatic logic [31:0] expi(input logic draw, input int x, input int y, input logic [2:0] c);
        logic [31:0] v;
        v = (32'(y) << 12) | (32'(x) << 4);
        v = draw ? (v | 32'h1 | (32'(c) << 19) | (32'h1 << 22)) : (v | 32'h2);
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clock);
            #1;
        end
    endtask

    task automatic pulse(input logic c, input logic r, input logic [2:0] col);
        cyc(1);
        clear_req = c;
        refresh_req = r;
        clear_colour = col;
        cyc(1);
        clear_req = 1'b0;
        refresh_req = 1'b0;
    endtask

    task automatic wait_frames(input int n);
        int k;
        k = 0;
        while (frames < n && k < 3000) begin
            cyc(1);
            k++;
        end
        check("frame_wait", 32'(frames >= n), 32'd1);
        cyc(5);
    endtask

    task automatic fresh();
        q.delete();
        frames = 0;
        stab_err = 0;
        busy_gaps = 0;
    endtask

    task automatic check_pass(input string tag, input int base, input logic draw, input logic [2:0] c);
        for (int i = 0; i < 12; i++)
            check(tag, (q.size() > base + i) ? q[base + i] : 32'hxxxxxxxx, expi(draw, i % 4, i / 4, c));
    endtask

    initial begin
        cyc(2);
        check("rst_start", 32'(dp_start), 32'd0);
        check("rst_instr", dp_instruction, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        reset = 1'b0;
        cyc(2);
        fresh();
        pulse(1'b0, 1'b1, 3'b000);
        check("latch_busy", 32'(busy), 32'd0);
        cyc(1);
        check("pass_busy", 32'(busy), 32'd1);
        wait_frames(1);
        check("ref_count", 32'(q.size()), 32'd12);
        check_pass("ref_instr", 0, 1'b0, 3'b000);
        check("ref_frames", 32'(frames), 32'd1);
        check("ref_done_at", 32'(starts_at_done), 32'd12);
        check("ref_busy_gap", 32'(busy_gaps), 32'd0);
        check("ref_idle", 32'(busy), 32'd0);
        fresh();
        pulse(1'b1, 1'b0, 3'b101);
        wait_frames(1);
        check("clr_count", 32'(q.size()), 32'd12);
        check_pass("clr_instr", 0, 1'b1, 3'b101);
        check("clr_frames", 32'(frames), 32'd1);
        fresh();
        pulse(1'b1, 1'b1, 3'b011);
        wait_frames(2);
        check("both_count", 32'(q.size()), 32'd24);
        check_pass("both_draw", 0, 1'b1, 3'b011);
        check_pass("both_disp", 12, 1'b0, 3'b000);
        check("both_frames", 32'(frames), 32'd2);
        check("both_idle", 32'(busy), 32'd0);
        fresh();
        pulse(1'b1, 1'b0, 3'b110);
        cyc(10);
        pulse(1'b0, 1'b1, 3'b000);
        cyc(7);
        pulse(1'b0, 1'b1, 3'b000);
        cyc(3);
        pulse(1'b0, 1'b1, 3'b000);
        wait_frames(2);
        cyc(200);
        check("coll_frames", 32'(frames), 32'd2);
        check("coll_count", 32'(q.size()), 32'd24);
        check("coll_last_draw", (q.size() > 11) ? q[11] : 32'hxxxxxxxx, expi(1'b1, 3, 2, 3'b110));
        check("coll_first_disp", (q.size() > 12) ? q[12] : 32'hxxxxxxxx, expi(1'b0, 0, 0, 3'b000));
        fresh();
        pulse(1'b0, 1'b1, 3'b000);
        for (int k = 0; k < 500 && q.size() < 5; k++)
            cyc(1);
        check("mid_starts", 32'(q.size()), 32'd5);
        check("mid_busy", 32'(busy), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("async_busy", 32'(busy), 32'd0);
        check("async_start", 32'(dp_start), 32'd0);
        check("async_instr", dp_instruction, 32'd0);
        check("async_done", 32'(frame_done), 32'd0);
        hold_low = 1'b1;
        cyc(2);
        reset = 1'b0;
        cyc(2);
        fresh();
        pulse(1'b0, 1'b1, 3'b000);
        cyc(10);
        check("hold_nostart", 32'(q.size()), 32'd0);
        check("hold_busy", 32'(busy), 32'd1);
        hold_low = 1'b0;
        wait_frames(1);
        check("post_rst_first", (q.size() > 0) ? q[0] : 32'hxxxxxxxx, expi(1'b0, 0, 0, 3'b000));
        check("post_rst_count", 32'(q.size()), 32'd12);
        fresh();
        lat = 20;
        pulse(1'b0, 1'b1, 3'b000);
        wait_frames(1);
        check("long_stable", 32'(stab_err), 32'd0);
        check("long_count", 32'(q.size()), 32'd12);
        check("long_last", (q.size() > 11) ? q[11] : 32'hxxxxxxxx, expi(1'b0, 3, 2, 3'b000));
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
